ip_conv_param: RTL and testbench
================================

Name: ip_conv_param

Overview:
Parametrised convolution/correlation IP core. It uses the standard IP-module slave interface (data_in/data_out/write/read/start/conf_dbus/int_req) and sits behind the MCU interface manager.
- Successor to the fixed convolution core.
- Generalises data width and maximum vector length.
- Adds runtime lengths, correlation mode, signed arithmetic, length-error detection and a maskable interrupt.

Parameters:
DATA_W, 8, width of X/Y samples
MAX_LEN, 32, max length of X and Y (2..4095); Z depth = 2*MAX_LEN-1
BUS_W, 32, data_in/data_out width; elaboration error if ACC_W > BUS_W
CONF_WIDTH, 5, conf_dbus width
ACC_W, 2*DATA_W+$clog2(MAX_LEN), derived localparam, accumulator/Z width

Ports:
clk  in  1  system clock
rst_a  in  1  asynchronous active-low reset
en_s  in  1  synchronous enable; 0 freezes all state, strobes ignored
data_in  in  BUS_W  write data
data_out  out  BUS_W  registered read data
write  in  1  single-cycle write strobe
read  in  1  single-cycle read strobe
start  in  1  single-cycle start strobe
conf_dbus  in  CONF_WIDTH  target select
int_req  out  1  level interrupt

Behaviour:
- Reset: data_out=0, int_req=0, status and CFG registers=0, pointer=0, FSM=IDLE. Memory contents are undefined after reset.
- conf_dbus codes:
  - 0x00 MEMX (wr)
  - 0x01 MEMY (wr)
  - 0x02 MEMZ (rd)
  - 0x03 CFG (wr/rd)
  - 0x1E STATUS (rd)
  - 0x1F INTCLR (wr)
  - Other codes: reads return 0, writes are ignored.
- CFG fields: [11:0] LX, [23:12] LY, [24] mode (0 conv, 1 correlation), [25] signed, [26] int_en.
- STATUS fields: [0] done, [1] busy, [2] err.
- Pointer:
  - A single auto-increment pointer.
  - Cleared when conf_dbus differs from its value in the previous cycle, and cleared on start.
  - Each MEMX/MEMY write or MEMZ read increments it.
  - Wraps modulo the target depth.
- Reads: data_out is updated one cycle after the read strobe. MEMZ values are sign-extended to BUS_W when signed=1, zero-extended otherwise.
- While busy:
  - Writes to MEMX/MEMY/CFG are ignored.
  - MEMZ reads return 0.
  - start is ignored.
  - STATUS/INTCLR remain functional.
- start in IDLE:
  - Clears done/err.
  - If LX=0, LY=0, LX>MAX_LEN or LY>MAX_LEN: err=1, done=1, go DONE. Z is untouched.
  - Otherwise go INIT.
- FSM: IDLE -> CHECK -> {INIT -> MAC -> DRAIN(2) -> STORE}×LZ -> DONE -> IDLE.
  - LZ = LX+LY-1.
  - INIT (1 cycle): compute k_lo=max(0,n-LY+1), k_hi=min(n,LX-1); clear acc.
  - MAC: one X/Y address pair per cycle. Y index is n-k in conv mode and LY-1-(n-k) in correlation mode.
  - RAM read latency is 1 cycle; product is registered; acc += product. DRAIN covers this latency.
  - STORE writes acc[ACC_W-1:0] to Z[n].
- Latency: cycles from the start strobe to int_req rising = LX*LY + 4*LZ + 2 (error case: 2). Exact; the bench checks it.
- Arithmetic: products are signed×signed when signed=1, unsigned otherwise. The accumulator cannot overflow by construction.
- DONE: done=1, busy=0. int_req = done & int_en.
- Interrupt clear: a write to INTCLR or a new start clears done and int_req. A start and an INTCLR write in the same cycle is a legal start.
- rst_a asserted mid-operation aborts immediately. Z holds partial results, treated as undefined.

Decomposition:
- Package conv_pkg:
  - conf codes
  - CFG/STATUS bit positions
  - FSM state enum
  - ACC_W function
- Sub-module conv_dpram: 1W/1R synchronous RAM, parametrised width and depth. Instantiated three times (X, Y, Z).
  - X and Y: write port owned by the MCU path, read port owned by the FSM.
  - Z: write port owned by the FSM, read port owned by the MCU path.

Test Plan:
1. Unsigned conv: X=[1,2,3], Y=[1,1], LX=3, LY=2, int_en=1, start -> Z=[1,3,5,3]; int_req rises exactly 24 cycles after start.
2. Correlation: same setup with X=[1,2,3], Y=[1,2], mode=1 -> Z=[2,5,8,3].
3. Signed: X=[0xFF,0x02], Y=[0x03], signed=1 -> Z reads 0xFFFFFFFD, 0x00000006.
4. Length error: LX=0 -> STATUS=0x5 two cycles after start; MEMZ contents unchanged; INTCLR write -> int_req=0, STATUS=0.
5. Abort and busy rules: rst_a low 3 cycles into MAC -> STATUS=0, int_req=0, data_out=0. Re-run test 1 -> passes. A second start during busy is ignored; the busy cycle count is unchanged.
6. Full scale: MAX_LEN=32, 32×0xFF in both vectors, unsigned -> Z[31]=2080800, Z[0]=Z[62]=65025; pointer wrap check on the 64th MEMZ read.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the parametrised convolution/correlation core:
// register map codes, CFG/STATUS field positions, FSM states, accumulator sizing.
package conv_pkg;

  localparam int unsigned CONF_MEMX   = 32'h00;
  localparam int unsigned CONF_MEMY   = 32'h01;
  localparam int unsigned CONF_MEMZ   = 32'h02;
  localparam int unsigned CONF_CFG    = 32'h03;
  localparam int unsigned CONF_STATUS = 32'h1E;
  localparam int unsigned CONF_INTCLR = 32'h1F;

  localparam int unsigned LEN_W      = 12;
  localparam int unsigned CFG_LX_LSB = 0;
  localparam int unsigned CFG_LY_LSB = 12;
  localparam int unsigned CFG_MODE   = 24;
  localparam int unsigned CFG_SIGNED = 25;
  localparam int unsigned CFG_INTEN  = 26;
  localparam int unsigned CFG_W      = 27;

  localparam int unsigned ST_DONE = 0;
  localparam int unsigned ST_BUSY = 1;
  localparam int unsigned ST_ERR  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_INIT,
    S_MAC,
    S_DRAIN1,
    S_DRAIN2,
    S_STORE,
    S_DONE
  } state_t;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned ml);
    return 2 * dw + $clog2(ml);
  endfunction

endpackage

// File: rtl/conv_dpram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Both ports freeze when en is low.
module conv_dpram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ip_conv_param.sv
// Parametrised convolution/correlation IP behind the MCU slave interface.
// X/Y are loaded through an auto-increment pointer; results land in Z.
module ip_conv_param
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MAX_LEN    = 32,
  parameter int unsigned BUS_W      = 32,
  parameter int unsigned CONF_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  en_s,
  input  logic [BUS_W-1:0]      data_in,
  output logic [BUS_W-1:0]      data_out,
  input  logic                  write,
  input  logic                  read,
  input  logic                  start,
  input  logic [CONF_WIDTH-1:0] conf_dbus,
  output logic                  int_req
);

  localparam int unsigned ACC_W = acc_width(DATA_W, MAX_LEN);
  localparam int unsigned AW    = $clog2(MAX_LEN);
  localparam int unsigned ZD    = 2 * MAX_LEN - 1;
  localparam int unsigned ZAW   = $clog2(ZD);
  localparam int unsigned IW    = LEN_W + 2;
  localparam int unsigned PW    = 2 * DATA_W;

  if (ACC_W > BUS_W) begin : g_bus_chk
    $error("ip_conv_param: ACC_W exceeds BUS_W");
  end

  state_t                state, state_nx;
  logic [CONF_WIDTH-1:0] conf_prev;
  logic [ZAW-1:0]        ptr, ptr_eff, ptr_nx;
  logic [CFG_W-1:0]      cfg;
  logic                  done, err, busy, go, len_bad;
  logic                  sel_x, sel_y, sel_z, sel_cfg, sel_st, sel_clr;
  logic                  wr_x, wr_y, wr_cfg, wr_clr, rd_z, rd_any;
  logic [LEN_W-1:0]      lx, ly;
  logic [IW-1:0]         lx14, ly14, lz_m1, n, k, k_hi, k_lo_c, k_hi_c, y_idx;
  logic [DATA_W-1:0]     x_rd, y_rd;
  logic [PW-1:0]         xe, ye, prod, prod_c;
  logic [ACC_W-1:0]      acc, prod_ext, z_rdata;
  logic                  mac_v1, mac_v2;
  logic [BUS_W-1:0]      rd_val;
  logic [31:0]           din32;
  logic                  unused_bits;

  assign din32       = 32'(data_in);
  assign unused_bits = ^{din32[31:CFG_W], y_idx[IW-1:AW]};

  assign lx   = cfg[CFG_LX_LSB +: LEN_W];
  assign ly   = cfg[CFG_LY_LSB +: LEN_W];
  assign lx14 = {2'b00, lx};
  assign ly14 = {2'b00, ly};
  assign lz_m1 = lx14 + ly14 - IW'(2);

  assign busy    = (state != S_IDLE);
  assign sel_x   = (conf_dbus == CONF_WIDTH'(CONF_MEMX));
  assign sel_y   = (conf_dbus == CONF_WIDTH'(CONF_MEMY));
  assign sel_z   = (conf_dbus == CONF_WIDTH'(CONF_MEMZ));
  assign sel_cfg = (conf_dbus == CONF_WIDTH'(CONF_CFG));
  assign sel_st  = (conf_dbus == CONF_WIDTH'(CONF_STATUS));
  assign sel_clr = (conf_dbus == CONF_WIDTH'(CONF_INTCLR));

  assign wr_x   = en_s & write & sel_x & ~busy;
  assign wr_y   = en_s & write & sel_y & ~busy;
  assign wr_cfg = en_s & write & sel_cfg & ~busy;
  assign wr_clr = en_s & write & sel_clr;
  assign rd_z   = en_s & read & sel_z & ~busy;
  assign rd_any = en_s & read;
  assign go     = en_s & start & (state == S_IDLE);

  assign len_bad = (lx == '0) || (ly == '0) ||
                   (lx > LEN_W'(MAX_LEN)) || (ly > LEN_W'(MAX_LEN));

  assign int_req = done & cfg[CFG_INTEN];

  // The pointer is treated as already cleared in the cycle conf_dbus changes,
  // and Z is read at ptr_nx so z_rdata always holds Z[ptr] for a 1-cycle read.
  always_comb begin
    ptr_eff = (conf_dbus != conf_prev) ? '0 : ptr;
    ptr_nx  = ptr_eff;
    if (wr_x || wr_y)
      ptr_nx = (ptr_eff == ZAW'(MAX_LEN - 1)) ? '0 : ptr_eff + 1'b1;
    else if (rd_z)
      ptr_nx = (ptr_eff == ZAW'(ZD - 1)) ? '0 : ptr_eff + 1'b1;
    if (en_s && start) ptr_nx = '0;
    if (!en_s) ptr_nx = ptr;
  end

  always_comb begin
    k_lo_c = (n + IW'(1) > ly14) ? n + IW'(1) - ly14 : '0;
    k_hi_c = (n < lx14 - IW'(1)) ? n : lx14 - IW'(1);
    y_idx  = cfg[CFG_MODE] ? ly14 - IW'(1) - (n - k) : n - k;
    xe     = cfg[CFG_SIGNED] ? PW'($signed(x_rd)) : PW'(x_rd);
    ye     = cfg[CFG_SIGNED] ? PW'($signed(y_rd)) : PW'(y_rd);
    // low PW bits of the product are identical for signed and unsigned operands
    prod_c = xe * ye;
    prod_ext = cfg[CFG_SIGNED] ? ACC_W'($signed(prod)) : ACC_W'(prod);
  end

  always_comb begin
    rd_val = '0;
    if (sel_z && !busy) begin
      if (cfg[CFG_SIGNED]) rd_val = BUS_W'($signed(z_rdata));
      else                 rd_val = BUS_W'(z_rdata);
    end else if (sel_cfg) begin
      rd_val = BUS_W'(cfg);
    end else if (sel_st) begin
      rd_val = BUS_W'({err, busy, done});
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (go) state_nx = S_CHECK;
      S_CHECK:  state_nx = len_bad ? S_DONE : S_INIT;
      S_INIT:   state_nx = S_MAC;
      S_MAC:    if (k == k_hi) state_nx = S_DRAIN1;
      S_DRAIN1: state_nx = S_DRAIN2;
      S_DRAIN2: state_nx = S_STORE;
      S_STORE:  state_nx = (n == lz_m1) ? S_DONE : S_INIT;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state     <= S_IDLE;
      conf_prev <= '0;
      ptr       <= '0;
    end else if (en_s) begin
      state     <= state_nx;
      conf_prev <= conf_dbus;
      ptr       <= ptr_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      cfg      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      n        <= '0;
      k        <= '0;
      k_hi     <= '0;
      acc      <= '0;
      prod     <= '0;
      mac_v1   <= 1'b0;
      mac_v2   <= 1'b0;
      data_out <= '0;
    end else if (en_s) begin
      mac_v1 <= (state == S_MAC);
      mac_v2 <= mac_v1;
      prod   <= prod_c;
      if (mac_v2) acc <= acc + prod_ext;
      if (wr_clr) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      case (state)
        S_IDLE: if (go) begin
          done <= 1'b0;
          err  <= 1'b0;
          n    <= '0;
        end
        S_CHECK: if (len_bad) err <= 1'b1;
        S_INIT: begin
          k    <= k_lo_c;
          k_hi <= k_hi_c;
          acc  <= '0;
        end
        S_MAC:   k <= k + IW'(1);
        S_STORE: n <= n + IW'(1);
        S_DONE:  done <= 1'b1;
        default: ;
      endcase
      if (wr_cfg) cfg <= din32[CFG_W-1:0];
      if (rd_any) data_out <= rd_val;
    end
  end

  conv_dpram #(.WIDTH(DATA_W), .DEPTH(MAX_LEN), .AW(AW)) u_xram (
    .clk   (clk),
    .en    (en_s),
    .we    (wr_x),
    .waddr (ptr_eff[AW-1:0]),
    .wdata (data_in[DATA_W-1:0]),
    .raddr (k[AW-1:0]),
    .rdata (x_rd)
  );

  conv_dpram #(.WIDTH(DATA_W), .DEPTH(MAX_LEN), .AW(AW)) u_yram (
    .clk   (clk),
    .en    (en_s),
    .we    (wr_y),
    .waddr (ptr_eff[AW-1:0]),
    .wdata (data_in[DATA_W-1:0]),
    .raddr (y_idx[AW-1:0]),
    .rdata (y_rd)
  );

  conv_dpram #(.WIDTH(ACC_W), .DEPTH(ZD), .AW(ZAW)) u_zram (
    .clk   (clk),
    .en    (en_s),
    .we    (state == S_STORE),
    .waddr (n[ZAW-1:0]),
    .wdata (acc),
    .raddr (ptr_nx),
    .rdata (z_rdata)
  );

endmodule

// File: tb/tb_ip_conv_param.sv
// Scoreboard bench for ip_conv_param: reads push expected words, a monitor
// compares data_out one cycle after each read strobe.
module tb_ip_conv_param;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        en_s;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        write, read, start;
  logic [4:0]  conf_dbus;
  logic        int_req;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  localparam logic [4:0] MEMX = 5'h00, MEMY = 5'h01, MEMZ = 5'h02, CFG = 5'h03,
                         STAT = 5'h1E, ICLR = 5'h1F;

  ip_conv_param #(.DATA_W(8), .MAX_LEN(32), .BUS_W(32), .CONF_WIDTH(5)) dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .en_s      (en_s),
    .data_in   (data_in),
    .data_out  (data_out),
    .write     (write),
    .read      (read),
    .start     (start),
    .conf_dbus (conf_dbus),
    .int_req   (int_req)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst_a === 1'b1 && en_s === 1'b1 && read === 1'b1) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read actual=0x%08h required=none", data_out);
        end else begin
          check(name_q.pop_front(), data_out, exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] mk_cfg(input int lx, input int ly, input bit mode,
                                         input bit sgn, input bit ien);
    return 32'(lx) | (32'(ly) << 12) | (32'(mode) << 24) | (32'(sgn) << 25) | (32'(ien) << 26);
  endfunction

  task automatic sel(input logic [4:0] code);
    @(negedge clk) conf_dbus = code;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] v);
    @(negedge clk);
    data_in = v;
    write   = 1'b1;
    @(negedge clk) write = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [31:0] exp);
    @(negedge clk);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    read = 1'b1;
    @(negedge clk) read = 1'b0;
  endtask

  // Start, then count cycles until int_req rises; optional extra start at cycle extra_at.
  task automatic start_timed(input string nm, input int exp_lat, input int maxc, input int extra_at);
    int cyc;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (cyc < maxc && int_req !== 1'b1) begin
      @(posedge clk);
      cyc++;
      #1 start = (cyc == extra_at);
    end
    start = 1'b0;
    check(nm, 32'(cyc), 32'(exp_lat));
  endtask

  task automatic load_conv1();
    sel(MEMX); wr(1); wr(2); wr(3);
    sel(MEMY); wr(1); wr(1);
    sel(CFG);  wr(mk_cfg(3, 2, 0, 0, 1));
  endtask

  initial begin
    rst_a = 1'b0; en_s = 1'b1; data_in = '0;
    write = 1'b0; read = 1'b0; start = 1'b0; conf_dbus = '0;
    repeat (3) @(negedge clk);
    check("rst_int_req", 32'(int_req), 0);
    check("rst_data_out", data_out, 0);
    rst_a = 1'b1;
    sel(STAT); rd("rst_status", 0);
    sel(CFG);  rd("rst_cfg", 0);

    // unsigned convolution
    load_conv1();
    rd("cfg_readback", mk_cfg(3, 2, 0, 0, 1));
    start_timed("lat_conv", 24, 200, 0);
    sel(STAT); rd("status_done", 32'h1);
    sel(MEMZ); rd("conv_z0", 1); rd("conv_z1", 3); rd("conv_z2", 5); rd("conv_z3", 3);

    // correlation
    sel(MEMY); wr(1); wr(2);
    sel(CFG);  wr(mk_cfg(3, 2, 1, 0, 1));
    start_timed("lat_corr", 24, 200, 0);
    sel(MEMZ); rd("corr_z0", 2); rd("corr_z1", 5); rd("corr_z2", 8); rd("corr_z3", 3);

    // signed
    sel(MEMX); wr(32'hFF); wr(32'h02);
    sel(MEMY); wr(32'h03);
    sel(CFG);  wr(mk_cfg(2, 1, 0, 1, 1));
    start_timed("lat_signed", 12, 200, 0);
    sel(MEMZ); rd("sgn_z0", 32'hFFFF_FFFD); rd("sgn_z1", 32'h6);

    // length error
    sel(CFG); wr(mk_cfg(0, 1, 0, 1, 1));
    start_timed("lat_err", 2, 50, 0);
    sel(STAT); rd("status_err", 32'h5);
    sel(MEMZ); rd("err_z0_kept", 32'hFFFF_FFFD); rd("err_z1_kept", 32'h6);
    sel(ICLR); wr(0);
    check("intclr_int_req", 32'(int_req), 0);
    sel(STAT); rd("status_cleared", 0);

    // abort mid-MAC
    load_conv1();
    rd("cfg_before_abort", mk_cfg(3, 2, 0, 0, 1));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    rst_a = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_int_req", 32'(int_req), 0);
    check("abort_data_out", data_out, 0);
    rst_a = 1'b1;
    sel(STAT); rd("abort_status", 0);

    // rerun with an ignored second start while busy
    load_conv1();
    start_timed("lat_rerun_busy_start", 24, 200, 5);
    sel(MEMZ); rd("rerun_z0", 1); rd("rerun_z1", 3); rd("rerun_z2", 5); rd("rerun_z3", 3);

    // enable low freezes the register file
    sel(CFG);
    en_s = 1'b0;
    wr(32'h1234);
    en_s = 1'b1;
    rd("cfg_frozen", mk_cfg(3, 2, 0, 0, 1));

    // full scale with pointer wrap
    sel(MEMX); for (int i = 0; i < 32; i++) wr(32'hFF);
    sel(MEMY); for (int i = 0; i < 32; i++) wr(32'hFF);
    sel(CFG);  wr(mk_cfg(32, 32, 0, 0, 1));
    start_timed("lat_full", 1278, 2000, 0);
    sel(MEMZ);
    for (int i = 0; i < 64; i++) begin
      int idx;
      int terms;
      idx   = i % 63;
      terms = (idx + 1 < 63 - idx) ? idx + 1 : 63 - idx;
      rd($sformatf("full_z%0d_read%0d", idx, i), 32'(terms * 65025));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
